// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl: bit-serial sequencer around a one-bit alu1 slice.
// Operands are shifted out LSB first, one bit per RUN cycle; the carry/borrow
// is held in a flop between bits and the result is shifted in from the top.
// Optional feature macro: ALU_SERIAL_OVERFLOW_EN adds out_ovf (signed overflow).

// One-bit ALU slice: select AND=0 NOT=1 OR=2 XOR=3 ADD=4 SUB=5 TRANSFER=6 TEST=7
module alu1 (
    input  logic       a,
    input  logic       b,
    input  logic       carry_in,
    input  logic [2:0] select,
    output logic       out,
    output logic       carry_out
);

    // Combinational bit function; carry_out is only meaningful for ADD/SUB
    always_comb begin
        out       = 1'b0;
        carry_out = 1'b0;
        case (select)
            3'd0: out = a & b;
            3'd1: out = ~a;
            3'd2: out = a | b;
            3'd3: out = a ^ b;
            3'd4: begin
                out       = a ^ b ^ carry_in;
                carry_out = (a & b) | (a & carry_in) | (b & carry_in);
            end
            3'd5: begin
                // borrow semantics: out = a - b - bin, carry_out = borrow
                out       = a ^ b ^ carry_in;
                carry_out = (~a & b) | (~a & carry_in) | (b & carry_in);
            end
            3'd6: out = a;
            default: out = a & b;
        endcase
    end

endmodule

module alu_serial_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_zero,
`ifdef ALU_SERIAL_OVERFLOW_EN
    output logic             out_ovf,
`endif
    output logic             out_err
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_NOT  = 3'd1,
        OP_OR   = 3'd2,
        OP_XOR  = 3'd3,
        OP_ADD  = 3'd4,
        OP_SUB  = 3'd5,
        OP_XFER = 3'd6,
        OP_TEST = 3'd7
    } op_e;

    state_e           r_state;
    op_e              r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_cout;
    logic             r_zero;
    logic             r_err;
`ifdef ALU_SERIAL_OVERFLOW_EN
    logic             r_ovf;
`endif

    logic             w_alu_out;
    logic             w_alu_cout;
    logic             w_arith;
    logic [WIDTH-1:0] w_res_next;

    alu1 u_alu1 (
        .a         (r_a[0]),
        .b         (r_b[0]),
        .carry_in  (r_carry),
        .select    (r_op),
        .out       (w_alu_out),
        .carry_out (w_alu_cout)
    );

    assign w_arith    = (r_op == OP_ADD) || (r_op == OP_SUB);
    assign w_res_next = {w_alu_out, r_res[WIDTH-1:1]};

    assign in_ready   = (r_state == S_IDLE);
    assign out_valid  = (r_state == S_DONE);
    assign out_result = r_res;
    assign out_carry  = r_cout;
    assign out_zero   = r_zero;
    assign out_err    = r_err;
`ifdef ALU_SERIAL_OVERFLOW_EN
    assign out_ovf    = r_ovf;
`endif

    // Sequencer FSM: accept request, shift WIDTH bits through alu1, hold result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_op    <= OP_AND;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_zero  <= 1'b0;
            r_err   <= 1'b0;
`ifdef ALU_SERIAL_OVERFLOW_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= in_a;
                        r_b     <= in_b;
                        r_op    <= op_e'(in_op);
                        r_carry <= in_cin;
                        r_cnt   <= '0;
                        r_res   <= '0;
                        r_cout  <= 1'b0;
`ifdef ALU_SERIAL_OVERFLOW_EN
                        r_ovf   <= 1'b0;
`endif
                        if (in_op >= 3'd6) begin
                            // unsupported serially: report immediately
                            r_state <= S_DONE;
                            r_zero  <= 1'b1;
                            r_err   <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                            r_zero  <= 1'b0;
                            r_err   <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    r_res <= w_res_next;
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_arith) begin
                        r_carry <= w_alu_cout;
                    end
                    if (r_cnt == LAST) begin
                        // r_a[0]/r_b[0]/w_alu_out are the MSBs on this last bit
                        r_state <= S_DONE;
                        r_cout  <= w_arith ? w_alu_cout : 1'b0;
                        r_zero  <= (w_res_next == '0);
                        r_err   <= 1'b0;
`ifdef ALU_SERIAL_OVERFLOW_EN
                        if (r_op == OP_ADD) begin
                            r_ovf <= (r_a[0] == r_b[0]) && (w_alu_out != r_a[0]);
                        end else if (r_op == OP_SUB) begin
                            r_ovf <= (r_a[0] != r_b[0]) && (w_alu_out != r_a[0]);
                        end else begin
                            r_ovf <= 1'b0;
                        end
`endif
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                        r_res   <= '0;
                        r_cout  <= 1'b0;
                        r_zero  <= 1'b0;
                        r_err   <= 1'b0;
`ifdef ALU_SERIAL_OVERFLOW_EN
                        r_ovf   <= 1'b0;
`endif
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
